// File: rtl/ahb_periph_pkg.sv
// ahb_periph_pkg: shared AHB peripheral register offsets, transfer encodings and field positions
package ahb_periph_pkg;
  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_STAT = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;
  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_COUNT    = 4;
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and synchronous flush
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int DW = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty & ~flush;
  assign rdata = mem[rd_ptr];
  // pointers and count; flush wins over any pop in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // storage is deliberately not reset
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/ahb2tx_fifo.sv
// ahb2tx_fifo: AHB-Lite slave pushing written bytes through a FIFO to a valid/ready sink
module ahb2tx_fifo
  import ahb_periph_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [31:0]   HADDR,
  input  logic [31:0]   HWDATA,
  input  logic          HWRITE,
  input  logic [1:0]    HTRANS,
  input  logic          HREADY,
  input  logic          HSEL,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          TX_IRQ,
  output logic [DW-1:0] TX_DATA,
  output logic          TX_VALID,
  input  logic          TX_READY
);
  logic last_sel, last_write, last_trans;
  logic [1:0] last_addr;
  logic irq_en, empty, full;
  logic [CW-1:0] count;
  logic active, wr_pend, ctrl_wr, push, flush;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:DW], HTRANS[0]};
  assign active = last_sel & last_trans;
  assign wr_pend = active & last_write & (last_addr == OFF_DATA);
  assign ctrl_wr = active & last_write & (last_addr == OFF_CTRL);
  assign HREADYOUT = ~(wr_pend & full);
  assign push = wr_pend & ~full;
  assign flush = ctrl_wr & HWDATA[CTRL_FLUSH];
  assign TX_VALID = ~empty;
  assign TX_IRQ = irq_en & empty;
  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk(HCLK),
    .rst_n(HRESETn),
    .push(push),
    .pop(TX_VALID & TX_READY),
    .flush(flush),
    .wdata(HWDATA[DW-1:0]),
    .rdata(TX_DATA),
    .empty(empty),
    .full(full),
    .count(count)
  );
  // address phase capture; holds while the data phase is stalled
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      last_sel <= 1'b0;
      last_write <= 1'b0;
      last_trans <= 1'b0;
      last_addr <= 2'd0;
    end else if (HREADY) begin
      last_sel <= HSEL;
      last_write <= HWRITE;
      last_trans <= HTRANS[1];
      last_addr <= HADDR[3:2];
    end
  // interrupt enable, written at the end of the CTRL data phase
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) irq_en <= 1'b0;
    else if (ctrl_wr) irq_en <= HWDATA[CTRL_IRQ_EN];
  // read mux; zero outside a read data phase
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_COUNT +: CW] = count;
    HRDATA = (~active | last_write) ? '0 :
             (last_addr == OFF_STAT) ? status :
             (last_addr == OFF_CTRL) ? 32'(irq_en) : '0;
  end
endmodule

// File: tb/tb_ahb2tx_fifo.sv
// tb_ahb2tx_fifo: randomized and directed checks of ahb2tx_fifo against a queue-based model
module tb_ahb2tx_fifo;
  localparam int DEPTH = 4;
  localparam int DW = 8;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0, HRDATA;
  logic HWRITE = 1'b0, HSEL = 1'b0, HREADY, HREADYOUT, TX_IRQ, TX_VALID, TX_READY = 1'b0;
  logic [1:0] HTRANS = 2'b00;
  logic [DW-1:0] TX_DATA;
  int errs = 0, checks = 0;
  logic [7:0] mq[$], mseen[$], dseen[$];
  bit m_irq, m_sel, m_wr, m_tr;
  logic [1:0] m_off;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb2tx_fifo #(.DEPTH(DEPTH), .DW(DW)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HREADY(HREADY), .HSEL(HSEL), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .TX_IRQ(TX_IRQ), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY)
  );

  // reference model: a byte queue plus the pending bus transfer
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mq.delete();
      m_irq = 0; m_sel = 0; m_wr = 0; m_tr = 0; m_off = 0;
    end else begin
      automatic bit full = mq.size() == DEPTH;
      automatic bit dph = m_sel && m_tr && m_wr;
      automatic bit to_data = dph && m_off == 2'd0;
      automatic bit to_ctrl = dph && m_off == 2'd2;
      if (mq.size() != 0 && TX_READY) mseen.push_back(mq[0]);
      if (to_ctrl) m_irq = HWDATA[0];
      if (to_ctrl && HWDATA[1]) mq.delete();
      else begin
        if (mq.size() != 0 && TX_READY) void'(mq.pop_front());
        if (to_data && !full) mq.push_back(HWDATA[7:0]);
      end
      if (!(to_data && full)) begin
        m_sel = HSEL; m_wr = HWRITE; m_tr = HTRANS[1]; m_off = HADDR[3:2];
      end
    end
  end

  // what the sink actually accepted
  always @(posedge HCLK)
    if (HRESETn && TX_VALID && TX_READY) dseen.push_back(TX_DATA);

  function automatic logic [31:0] status_of(int n);
    return 32'(n * 16) | (n == DEPTH ? 32'd2 : 32'd0) | (n == 0 ? 32'd1 : 32'd0);
  endfunction

  task automatic ahb(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic [31:0] exp);
    int n = 0;
    @(negedge HCLK);
    HSEL = 1; HADDR = a; HWRITE = wr; HTRANS = 2'b10;
    @(negedge HCLK);
    HSEL = 0; HADDR = 0; HWRITE = 0; HTRANS = 2'b00; HWDATA = wd;
    while (!HREADYOUT && n < 20) begin @(negedge HCLK); n++; end
    checks++;
    if (!HREADYOUT) begin errs++; $display("FAIL ahb_timeout: HREADYOUT still %b after %0d cycles, need 1", HREADYOUT, n); end
    rd = HRDATA;
    exp = a[3:2] == 2'd1 ? status_of(mq.size()) : a[3:2] == 2'd2 ? 32'(m_irq) : 32'd0;
    @(negedge HCLK);
  endtask

  task automatic test_reset;
    logic [31:0] rd, exp;
    repeat (3) @(negedge HCLK);
    checks += 4;
    if (HREADYOUT !== 1'b1) begin errs++; $display("FAIL rst_hreadyout: got %b need 1", HREADYOUT); end
    if (TX_VALID !== 1'b0) begin errs++; $display("FAIL rst_tx_valid: got %b need 0", TX_VALID); end
    if (TX_IRQ !== 1'b0) begin errs++; $display("FAIL rst_irq: got %b need 0", TX_IRQ); end
    if (HRDATA !== 32'h0) begin errs++; $display("FAIL rst_hrdata: got %h need 0", HRDATA); end
    HRESETn = 1;
    ahb(0, 32'h4, 0, rd, exp);
    checks++;
    if (rd !== 32'h1 || exp !== 32'h1) begin errs++; $display("FAIL rst_status: got %h need 1", rd); end
  endtask

  task automatic test_irq;
    logic [31:0] rd, exp;
    TX_READY = 0;
    ahb(1, 32'h8, 32'h1, rd, exp);
    checks++;
    if (TX_IRQ !== 1'b1) begin errs++; $display("FAIL irq_on_empty: got %b need 1", TX_IRQ); end
    ahb(1, 32'h0, 32'hA5, rd, exp);
    checks += 3;
    if (TX_VALID !== 1'b1) begin errs++; $display("FAIL push_valid: got %b need 1", TX_VALID); end
    if (TX_DATA !== 8'hA5) begin errs++; $display("FAIL push_data: got %h need a5", TX_DATA); end
    if (TX_IRQ !== 1'b0) begin errs++; $display("FAIL irq_off: got %b need 0", TX_IRQ); end
    TX_READY = 1;
    @(negedge HCLK);
    TX_READY = 0;
    checks += 2;
    if (TX_VALID !== 1'b0) begin errs++; $display("FAIL drain_valid: got %b need 0", TX_VALID); end
    if (TX_IRQ !== 1'b1) begin errs++; $display("FAIL irq_back: got %b need 1", TX_IRQ); end
  endtask

  task automatic test_stall;
    logic [31:0] rd, exp;
    logic [7:0] want [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int base;
    TX_READY = 0;
    for (int i = 0; i < 4; i++) ahb(1, 32'h0, 32'(want[i]), rd, exp);
    ahb(0, 32'h4, 0, rd, exp);
    checks++;
    if (rd !== 32'h42 || exp !== 32'h42) begin errs++; $display("FAIL full_status: got %h need 42", rd); end
    base = dseen.size();
    @(negedge HCLK);
    HSEL = 1; HADDR = 0; HWRITE = 1; HTRANS = 2'b10;
    @(negedge HCLK);
    HSEL = 0; HWRITE = 0; HTRANS = 2'b00; HWDATA = 32'h55;
    checks++;
    if (HREADYOUT !== 1'b0) begin errs++; $display("FAIL stall_start: got %b need 0", HREADYOUT); end
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b0) begin errs++; $display("FAIL stall_hold: got %b need 0", HREADYOUT); end
    TX_READY = 1;
    @(negedge HCLK);
    TX_READY = 0;
    checks += 2;
    if (HREADYOUT !== 1'b1) begin errs++; $display("FAIL stall_release: got %b need 1", HREADYOUT); end
    if (TX_DATA !== 8'h22) begin errs++; $display("FAIL head_after_pop: got %h need 22", TX_DATA); end
    @(negedge HCLK);
    ahb(0, 32'h4, 0, rd, exp);
    checks++;
    if (rd !== 32'h42 || exp !== 32'h42) begin errs++; $display("FAIL refill_status: got %h need 42", rd); end
    TX_READY = 1;
    repeat (6) @(negedge HCLK);
    TX_READY = 0;
    checks += 2;
    if (TX_VALID !== 1'b0) begin errs++; $display("FAIL stall_drained: got %b need 0", TX_VALID); end
    if (dseen.size() - base !== 5) begin errs++; $display("FAIL stall_count: got %0d need 5", dseen.size() - base); end
    for (int i = 0; i < 5 && base + i < dseen.size(); i++) begin
      checks++;
      if (dseen[base + i] !== want[i]) begin errs++; $display("FAIL stall_order[%0d]: got %h need %h", i, dseen[base + i], want[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int base = dseen.size(), stalls = 0;
    TX_READY = 1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge HCLK);
      if (!HREADYOUT) stalls++;
      HWDATA = 32'(i);
      HSEL = i < 8; HADDR = 0; HWRITE = i < 8; HTRANS = i < 8 ? 2'b10 : 2'b00;
    end
    repeat (3) @(negedge HCLK);
    TX_READY = 0;
    checks += 2;
    if (stalls !== 0) begin errs++; $display("FAIL b2b_stalls: got %0d need 0", stalls); end
    if (dseen.size() - base !== 8) begin errs++; $display("FAIL b2b_count: got %0d need 8", dseen.size() - base); end
    for (int k = 0; k < 8 && base + k < dseen.size(); k++) begin
      checks++;
      if (dseen[base + k] !== 8'(k + 1)) begin errs++; $display("FAIL b2b_order[%0d]: got %h need %h", k, dseen[base + k], k + 1); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] rd, exp;
    TX_READY = 0;
    for (int i = 0; i < 3; i++) ahb(1, 32'h0, 32'hC1 + 32'(i), rd, exp);
    TX_READY = 1;
    ahb(1, 32'h8, 32'h3, rd, exp);
    TX_READY = 0;
    checks += 2;
    if (TX_VALID !== 1'b0) begin errs++; $display("FAIL flush_valid: got %b need 0", TX_VALID); end
    if (TX_IRQ !== 1'b1) begin errs++; $display("FAIL flush_irq: got %b need 1", TX_IRQ); end
    ahb(0, 32'h8, 0, rd, exp);
    checks++;
    if (rd !== 32'h1 || exp !== 32'h1) begin errs++; $display("FAIL flush_ctrl_read: got %h need 1", rd); end
    ahb(0, 32'h4, 0, rd, exp);
    checks++;
    if (rd !== 32'h1 || exp !== 32'h1) begin errs++; $display("FAIL flush_status: got %h need 1", rd); end
  endtask

  task automatic test_reset_stall;
    logic [31:0] rd, exp;
    TX_READY = 0;
    for (int i = 0; i < 4; i++) ahb(1, 32'h0, 32'hD0 + 32'(i), rd, exp);
    @(negedge HCLK);
    HSEL = 1; HADDR = 0; HWRITE = 1; HTRANS = 2'b10;
    @(negedge HCLK);
    HSEL = 0; HWRITE = 0; HTRANS = 2'b00; HWDATA = 32'hD4;
    checks++;
    if (HREADYOUT !== 1'b0) begin errs++; $display("FAIL rs_stall: got %b need 0", HREADYOUT); end
    #2 HRESETn = 0;
    #1;
    checks += 4;
    if (HREADYOUT !== 1'b1) begin errs++; $display("FAIL rs_hreadyout: got %b need 1", HREADYOUT); end
    if (TX_VALID !== 1'b0) begin errs++; $display("FAIL rs_valid: got %b need 0", TX_VALID); end
    if (TX_IRQ !== 1'b0) begin errs++; $display("FAIL rs_irq: got %b need 0", TX_IRQ); end
    if (HRDATA !== 32'h0) begin errs++; $display("FAIL rs_hrdata: got %h need 0", HRDATA); end
    @(negedge HCLK);
    HRESETn = 1;
    ahb(1, 32'h0, 32'h77, rd, exp);
    checks += 2;
    if (TX_VALID !== 1'b1) begin errs++; $display("FAIL rs_after_valid: got %b need 1", TX_VALID); end
    if (TX_DATA !== 8'h77) begin errs++; $display("FAIL rs_after_data: got %h need 77", TX_DATA); end
    ahb(0, 32'h4, 0, rd, exp);
    checks++;
    if (rd !== 32'h10 || exp !== 32'h10) begin errs++; $display("FAIL rs_status: got %h need 10", rd); end
  endtask

  task automatic test_random;
    logic [31:0] rd, exp;
    for (int it = 0; it < 200; it++) begin
      int op = $urandom_range(0, 5);
      TX_READY = ($urandom_range(0, 2) != 0) || (op < 3 && mq.size() == DEPTH);
      if (op < 3) ahb(1, 32'h0, $urandom, rd, exp);
      else if (op == 5) ahb(1, 32'h8, {30'($urandom), $urandom_range(0, 3) == 0, 1'($urandom)}, rd, exp);
      else begin
        ahb(0, op == 3 ? 32'h4 : 32'h8, 0, rd, exp);
        checks++;
        if (rd !== exp) begin errs++; $display("FAIL rnd_read[%0d]: got %h need %h", it, rd, exp); end
      end
      checks += 2;
      if (TX_VALID !== (mq.size() != 0)) begin errs++; $display("FAIL rnd_valid[%0d]: got %b need %b", it, TX_VALID, mq.size() != 0); end
      if (TX_IRQ !== (m_irq && mq.size() == 0)) begin errs++; $display("FAIL rnd_irq[%0d]: got %b need %b", it, TX_IRQ, m_irq && mq.size() == 0); end
      if (mq.size() != 0) begin
        checks++;
        if (TX_DATA !== mq[0]) begin errs++; $display("FAIL rnd_data[%0d]: got %h need %h", it, TX_DATA, mq[0]); end
      end
    end
    TX_READY = 0;
  endtask

  task automatic test_sink_log;
    checks++;
    if (dseen.size() !== mseen.size()) begin errs++; $display("FAIL sink_len: got %0d need %0d", dseen.size(), mseen.size()); end
    for (int i = 0; i < dseen.size() && i < mseen.size(); i++) begin
      checks++;
      if (dseen[i] !== mseen[i]) begin errs++; $display("FAIL sink[%0d]: got %h need %h", i, dseen[i], mseen[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_irq;
    test_stall;
    test_back_to_back;
    test_flush;
    test_reset_stall;
    test_random;
    test_sink_log;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ahb2tx_fifo.md
Name: ahb2tx_fifo

Overview:
- AHB-Lite slave, write-direction counterpart of the key input peripheral: the CPU writes bytes that drain to an output device (LED/segment/motor command sink) over a valid/ready handshake.
- Small synchronous FIFO decouples the bus from the sink.
- HREADYOUT stalls a data write only while the FIFO is full.
- Status/control registers are readable; a level IRQ requests refill.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DW, 8, payload width; must be at most 8.
- CW, $clog2(DEPTH)+1, occupancy count width (derived; do not override).

Ports:
- HCLK  in  1  clock; single clock domain.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  32  address; only HADDR[3:2] decoded.
- HWDATA  in  32  write data, valid in data phase.
- HWRITE  in  1  1 = write.
- HTRANS  in  2  transfer type; HTRANS[1] = 1 marks an active transfer.
- HREADY  in  1  bus ready; address phase is sampled when high.
- HSEL  in  1  slave select.
- HREADYOUT  out  1  low = stall the current data phase.
- HRDATA  out  32  read data.
- TX_IRQ  out  1  refill interrupt, level.
- TX_DATA  out  DW  FIFO head.
- TX_VALID  out  1  FIFO non-empty.
- TX_READY  in  1  sink accepts TX_DATA this cycle.

Behaviour:
- Address phase:
  - When HREADY=1, register HSEL, HWRITE, HTRANS[1] and HADDR[3:2] into last_* flops.
  - These flops reset to 0 asynchronously.
  - Active data phase = last_HSEL & last_HTRANS1.
- Register map (word offsets):
  - 0x0 DATA, write-only. Write pushes HWDATA[DW-1:0]. Read returns 0.
  - 0x4 STATUS, read-only. bit0 = empty, bit1 = full, bits[CW+3:4] = count, other bits 0. Writes ignored.
  - 0x8 CTRL, read/write.
    - bit0 irq_en: reset value 0.
    - bit1 flush: write-1, self-clearing; reads as 0.
  - 0xC: reads 0, writes ignored.
- Write stall:
  - wr_pend = active data phase & last_HWRITE & offset==DATA.
  - HREADYOUT = ~(wr_pend & full).
  - Push occurs in the cycle wr_pend & ~full.
  - full is the registered state at the start of the cycle. There is no bypass: a pop in the same cycle that full=1 does not allow a push that cycle; the push happens the next cycle. This costs one stall cycle.
  - While stalled, HREADY is low, so the last_* flops hold and the push completes exactly once.
- Reads and non-DATA writes never stall.
- HRDATA is combinational from the last_* flops and current state during the data phase; it is 0 otherwise.
- CTRL write takes effect at the end of its data-phase cycle.
- Sink side:
  - TX_VALID = ~empty; TX_DATA = mem[rd_ptr].
  - Pop when TX_VALID & TX_READY.
  - TX_DATA stays stable while TX_VALID=1 and TX_READY=0.
- Simultaneous push and pop when not full and not empty: both occur; count is unchanged; pointers advance.
- Push into an empty FIFO: TX_VALID rises on the next cycle (1-cycle latency from the write data phase).
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is CW bits, 0..DEPTH.
- Flush:
  - Sets rd_ptr = wr_ptr = 0 and count = 0 in the next cycle.
  - Flush wins over a simultaneous pop.
  - A flush write cannot coincide with a DATA push, since there is one transfer per data phase.
- TX_IRQ = irq_en & empty, level, combinational from registered state.
- Reset (async, any time, including mid-stall):
  - count=0, pointers=0, irq_en=0, last_*=0.
  - Outputs: HREADYOUT=1, HRDATA=0, TX_VALID=0, TX_IRQ=0, TX_DATA = mem[0].
  - FIFO memory is not reset; TX_DATA is don't-care while TX_VALID=0.
- Error response (HRESP) is not used; the slave always responds OKAY.

Decomposition:
- Shared package ahb_periph_pkg:
  - Register offset constants OFF_DATA=2'd0, OFF_STAT=2'd1, OFF_CTRL=2'd2.
  - HTRANS encodings.
  - STATUS bit positions.
- One sub-module, sync_fifo:
  - Parameters DEPTH, DW.
  - Ports: push, pop, flush, wdata, rdata, empty, full, count.
  - The top level holds the AHB decode, stall logic, CTRL register and IRQ.

Test Plan:
- Reset, then read STATUS (0x4) -> HRDATA=0x1 (empty); TX_VALID=0; TX_IRQ=0; HREADYOUT=1.
- Write CTRL=0x1 with TX_READY=0 -> TX_IRQ=1. Write DATA=0xA5 -> TX_VALID=1 one cycle later, TX_DATA=0xA5, TX_IRQ=0.
- TX_READY=0, write 0x11,0x22,0x33,0x44 (DEPTH=4) -> STATUS read=0x42. Fifth write 0x55 -> HREADYOUT=0.
  - Raise TX_READY for 1 cycle -> 0x11 popped, 0x55 pushed the following cycle, HREADYOUT returns to 1.
  - Drain order is 0x22,0x33,0x44,0x55.
- TX_READY=1 constantly, back-to-back writes 0x01..0x08 -> the sink sees 0x01..0x08 in order with no stalls; count never exceeds 2.
- Fill with 3 bytes, write CTRL=0x3 while TX_READY=1 -> next cycle count=0, TX_VALID=0, TX_IRQ=1, irq_en read back as 1, flush bit reads 0.
- Assert HRESETn=0 mid-stall (FIFO full, HREADYOUT=0) -> HREADYOUT=1, TX_VALID=0, count=0 immediately. After release, a DATA write is accepted normally.
